load_store_unit: RTL and testbench

Sits between the execute stage and `data_memory` and turns byte, halfword and word loads/stores into the word-only, single-port accesses `data_memory` supports. It converts byte addresses to word indices and sign- or zero-extends load results. Sub-word stores are handled as a two-access read-modify-write. A small FSM sequences each access and exposes a ready/valid handshake so the pipeline can stall while a request is in flight.

---
 rtl/load_store_unit.sv | 251 +++++++++++++++++++++++++
 tb/tb_load_store_unit.sv | 330 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/load_store_unit.sv
// load_store_unit
// Converts byte/halfword/word loads and stores from the execute stage into
// word-only accesses on a single-port data memory. Sub-word stores are done
// as a read-modify-write pair. One request is in flight at a time.
//
// Optional feature macro: LSU_MISALIGN_TRAP_EN
//   defined   : misaligned halfword/word requests make no memory access and
//               complete with resp_error = 1.
//   undefined : misaligned requests proceed aligned (low address bits ignored)
//               and resp_error is tied to 0.

module load_store_unit #(
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [1:0]        req_size,
    input  logic              req_signed,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [31:0]       req_wdata,
    output logic              resp_valid,
    output logic [31:0]       resp_rdata,
    output logic              resp_error,
    output logic              mem_read,
    output logic              mem_write,
    output logic [31:0]       mem_address,
    output logic [31:0]       mem_write_data,
    input  logic [31:0]       mem_read_data
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_LD     = 3'd1,
        S_ST     = 3'd2,
        S_RMW_RD = 3'd3,
        S_RMW_WR = 3'd4,
        S_ERR    = 3'd5,
        S_RESP   = 3'd6
    } state_t;

    state_t      state_q;
    state_t      state_d;
    logic        accept_s;
    logic        trap_s;

    // Request fields captured at accept; req_* are ignored afterwards.
    logic [1:0]  size_q;
    logic        signed_q;
    logic [31:0] wdata_q;
    logic [1:0]  lane_q;

    // Registered outputs.
    logic        req_ready_q;
    logic        resp_valid_q;
    logic        mem_read_q;
    logic        mem_write_q;
    logic [31:0] resp_rdata_q;
    logic [31:0] mem_address_q;
    logic [31:0] mem_write_data_q;

    // Select and extend the addressed lane(s) of a memory word.
    // Halfwords use lane pair lane[1]; lane[0] is ignored here.
    function automatic logic [31:0] load_extract(
        input logic [31:0] word,
        input logic [1:0]  size,
        input logic [1:0]  lane,
        input logic        sgn
    );
        logic [7:0]  b;
        logic [15:0] h;
        logic [31:0] r;
        b = word[{lane, 3'b000} +: 8];
        h = lane[1] ? word[31:16] : word[15:0];
        case (size)
            2'b00: r = sgn ? {{24{b[7]}}, b} : {24'h000000, b};
            2'b01: r = sgn ? {{16{h[15]}}, h} : {16'h0000, h};
            default: r = word;
        endcase
        return r;
    endfunction

    // Replace the target lane(s) of the old word with right-justified store data.
    function automatic logic [31:0] store_merge(
        input logic [31:0] old_word,
        input logic [31:0] wd,
        input logic [1:0]  size,
        input logic [1:0]  lane
    );
        logic [31:0] m;
        m = old_word;
        case (size)
            2'b00: m[{lane, 3'b000} +: 8] = wd[7:0];
            2'b01: begin
                if (lane[1]) begin
                    m[31:16] = wd[15:0];
                end else begin
                    m[15:0] = wd[15:0];
                end
            end
            default: m = wd;
        endcase
        return m;
    endfunction

`ifdef LSU_MISALIGN_TRAP_EN
    logic resp_error_q;

    // Halfwords must be 2-byte aligned, words 4-byte aligned; bytes never trap.
    function automatic logic is_misaligned(
        input logic [1:0] size,
        input logic [1:0] lane
    );
        logic r;
        case (size)
            2'b00:   r = 1'b0;
            2'b01:   r = lane[0];
            default: r = (lane != 2'b00);
        endcase
        return r;
    endfunction

    assign trap_s     = is_misaligned(req_size, req_addr[1:0]);
    assign resp_error = resp_error_q;
`else
    assign trap_s     = 1'b0;
    assign resp_error = 1'b0;
`endif

    // Next-state logic: sequence one request from accept through the response cycle.
    always_comb begin
        state_d  = state_q;
        accept_s = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (req_valid) begin
                    accept_s = 1'b1;
                    if (trap_s) begin
                        state_d = S_ERR;
                    end else if (!req_write) begin
                        state_d = S_LD;
                    end else if (req_size[1]) begin
                        state_d = S_ST;
                    end else begin
                        state_d = S_RMW_RD;
                    end
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_LD:     state_d = S_RESP;
            S_ST:     state_d = S_RESP;
            S_RMW_RD: state_d = S_RMW_WR;
            S_RMW_WR: state_d = S_RESP;
            S_ERR:    state_d = S_RESP;
            S_RESP:   state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
    end

    // FSM state register; reset abandons any request in flight.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Capture the request fields on the accept edge.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            size_q   <= 2'b00;
            signed_q <= 1'b0;
            wdata_q  <= 32'h0000_0000;
            lane_q   <= 2'b00;
        end else if (accept_s) begin
            size_q   <= req_size;
            signed_q <= req_signed;
            wdata_q  <= req_wdata;
            lane_q   <= req_addr[1:0];
        end
    end

    // Strobes and handshake flags are decoded from the next state so they
    // come straight from flops and track the state register cycle for cycle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            req_ready_q  <= 1'b1;
            resp_valid_q <= 1'b0;
            mem_read_q   <= 1'b0;
            mem_write_q  <= 1'b0;
        end else begin
            req_ready_q  <= (state_d == S_IDLE);
            resp_valid_q <= (state_d == S_RESP);
            mem_read_q   <= (state_d == S_LD) || (state_d == S_RMW_RD);
            mem_write_q  <= (state_d == S_ST) || (state_d == S_RMW_WR);
        end
    end

`ifdef LSU_MISALIGN_TRAP_EN
    // Error flag accompanies the response that follows the ERR state.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            resp_error_q <= 1'b0;
        end else begin
            resp_error_q <= (state_d == S_RESP) && (state_q == S_ERR);
        end
    end
`endif

    // Word index is latched at accept and held until the next request.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mem_address_q <= 32'h0000_0000;
        end else if (accept_s) begin
            mem_address_q <= 32'(req_addr >> 2);
        end
    end

    // Load data path: extract and extend on the edge that ends the LD cycle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            resp_rdata_q <= 32'h0000_0000;
        end else if (state_q == S_LD) begin
            resp_rdata_q <= load_extract(mem_read_data, size_q, lane_q, signed_q);
        end
    end

    // Write data: full word for word stores, merged word at the end of RMW_RD.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mem_write_data_q <= 32'h0000_0000;
        end else if (accept_s && (state_d == S_ST)) begin
            mem_write_data_q <= req_wdata;
        end else if (state_q == S_RMW_RD) begin
            mem_write_data_q <= store_merge(mem_read_data, wdata_q, size_q, lane_q);
        end
    end

    assign req_ready      = req_ready_q;
    assign resp_valid     = resp_valid_q;
    assign resp_rdata     = resp_rdata_q;
    assign mem_read       = mem_read_q;
    assign mem_write      = mem_write_q;
    assign mem_address    = mem_address_q;
    assign mem_write_data = mem_write_data_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Scoreboard bench for load_store_unit. A small word memory stands in for
// data_memory; a byte-level reference model predicts every response.
// The response cycle of a request accepted at edge T0 is the cycle closed by
// edge T2 (T3 for sub-word stores), i.e. latency 1 (2) cycles after T0.

module tb_load_store_unit;

    logic        clk;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [1:0]  req_size;
    logic        req_signed;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_error;
    logic        mem_read;
    logic        mem_write;
    logic [31:0] mem_address;
    logic [31:0] mem_write_data;
    logic [31:0] mem_read_data;

`ifdef LSU_MISALIGN_TRAP_EN
    localparam bit TRAP = 1'b1;
`else
    localparam bit TRAP = 1'b0;
`endif

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        int          lat;
        int          nrd;
        int          nwr;
        logic [31:0] widx;
        int          t0;
    } exp_t;

    exp_t        exp_q[$];
    logic [31:0] mem_arr [16];
    logic [31:0] ref_mem [16];
    logic [31:0] last_rdata;
    int          checks = 0;
    int          errors = 0;
    int          cyc    = 0;
    int          rd_cnt = 0;
    int          wr_cnt = 0;

    load_store_unit #(.ADDR_W(32)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_size(req_size), .req_signed(req_signed), .req_addr(req_addr),
        .req_wdata(req_wdata), .resp_valid(resp_valid), .resp_rdata(resp_rdata),
        .resp_error(resp_error), .mem_read(mem_read), .mem_write(mem_write),
        .mem_address(mem_address), .mem_write_data(mem_write_data),
        .mem_read_data(mem_read_data)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        forever begin
            @(posedge clk);
            cyc++;
        end
    end

    function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endfunction

    // Reference model: byte-addressed view of memory, plain arithmetic.
    function automatic exp_t model(input logic wr, input logic [1:0] size, input logic sgn,
                                   input logic [31:0] addr, input logic [31:0] wd, input bit commit);
        exp_t        e;
        int          idx;
        int          off;
        bit          mis;
        logic [31:0] w;
        logic [31:0] v;
        logic [31:0] mask;
        logic [31:0] nw;
        idx    = int'(addr / 32'd4);
        off    = int'(addr % 32'd4);
        w      = ref_mem[idx];
        mis    = TRAP && (((size == 2'b01) && (off % 2 == 1)) || ((size >= 2'b10) && (off != 0)));
        e.widx = addr / 32'd4;
        e.t0   = 0;
        e.err  = 1'b0;
        e.rdata = last_rdata;
        e.nrd  = 0;
        e.nwr  = 0;
        e.lat  = 1;
        if (mis) begin
            e.err = 1'b1;
        end else if (!wr) begin
            if (size == 2'b00) begin
                v = (w >> (8 * off)) & 32'h0000_00FF;
                if (sgn && v >= 32'd128) v = v | 32'hFFFF_FF00;
            end else if (size == 2'b01) begin
                v = (w >> (16 * (off / 2))) & 32'h0000_FFFF;
                if (sgn && v >= 32'd32768) v = v | 32'hFFFF_0000;
            end else begin
                v = w;
            end
            last_rdata = v;
            e.rdata = v;
            e.nrd = 1;
        end else begin
            if (size == 2'b00) begin
                mask  = 32'h0000_00FF << (8 * off);
                nw    = (w & ~mask) | ((wd & 32'h0000_00FF) << (8 * off));
                e.lat = 2;
                e.nrd = 1;
            end else if (size == 2'b01) begin
                mask  = 32'h0000_FFFF << (16 * (off / 2));
                nw    = (w & ~mask) | ((wd & 32'h0000_FFFF) << (16 * (off / 2)));
                e.lat = 2;
                e.nrd = 1;
            end else begin
                nw = wd;
            end
            e.nwr = 1;
            if (commit) ref_mem[idx] = nw;
        end
        return e;
    endfunction

    // Memory stand-in: read data appears on negedge, writes land on posedge.
    initial begin
        mem_read_data = 32'h0000_0000;
        forever begin
            @(negedge clk);
            if (mem_read) mem_read_data = mem_arr[mem_address[3:0]];
        end
    end

    initial begin
        forever begin
            @(posedge clk);
            if (mem_write && !reset) mem_arr[mem_address[3:0]] = mem_write_data;
        end
    end

    // Monitor: per-cycle protocol checks and in-order response scoreboard.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (reset) begin
                exp_q.delete();
                rd_cnt = 0;
                wr_cnt = 0;
            end else begin
                chk("rd_wr_exclusive", {31'd0, mem_read & mem_write}, 32'd0);
                if (exp_q.size() > 0) begin
                    if (!resp_valid) chk("busy_ready", {31'd0, req_ready}, 32'd0);
                    if (mem_read || mem_write) chk("mem_address", mem_address, exp_q[0].widx);
                    if (mem_read) rd_cnt++;
                    if (mem_write) wr_cnt++;
                    if (resp_valid) begin
                        e = exp_q.pop_front();
                        chk("resp_rdata", resp_rdata, e.rdata);
                        chk("resp_error", {31'd0, resp_error}, {31'd0, e.err});
                        chk("resp_latency", 32'(cyc - e.t0), 32'(e.lat));
                        chk("read_cycles", 32'(rd_cnt), 32'(e.nrd));
                        chk("write_cycles", 32'(wr_cnt), 32'(e.nwr));
                        rd_cnt = 0;
                        wr_cnt = 0;
                    end
                end else begin
                    chk("idle_outputs", {28'd0, req_ready, resp_valid, mem_read, mem_write}, 32'h8);
                end
            end
        end
    end

    task automatic issue(input logic wr, input logic [1:0] size, input logic sgn,
                         input logic [31:0] addr, input logic [31:0] wd, input bit commit);
        int   waited;
        exp_t e;
        @(negedge clk);
        req_write  = wr;
        req_size   = size;
        req_signed = sgn;
        req_addr   = addr;
        req_wdata  = wd;
        req_valid  = 1'b1;
        waited = 0;
        while (!req_ready && waited < 40) begin
            @(negedge clk);
            waited++;
        end
        if (!req_ready) begin
            checks++;
            errors++;
            $display("FAIL accept_timeout: req_ready %b, expected 1", req_ready);
            req_valid = 1'b0;
        end else begin
            @(posedge clk);
            #1;
            e = model(wr, size, sgn, addr, wd, commit);
            e.t0 = cyc;
            exp_q.push_back(e);
        end
    endtask

    task automatic idle();
        @(negedge clk);
        req_valid = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 60) begin
            @(negedge clk);
            n++;
        end
        chk("drain_outstanding", 32'(exp_q.size()), 32'd0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset      = 1'b1;
        req_valid  = 1'b0;
        req_write  = 1'b0;
        req_size   = 2'b00;
        req_signed = 1'b0;
        req_addr   = 32'h0;
        req_wdata  = 32'h0;
        last_rdata = 32'h0;
        for (int i = 0; i < 16; i++) begin
            mem_arr[i] = $urandom;
            ref_mem[i] = mem_arr[i];
        end
        repeat (3) @(negedge clk);
        #1;
        chk("rst_req_ready", {31'd0, req_ready}, 32'd1);
        chk("rst_resp_valid", {31'd0, resp_valid}, 32'd0);
        chk("rst_resp_error", {31'd0, resp_error}, 32'd0);
        chk("rst_strobes", {30'd0, mem_read, mem_write}, 32'd0);
        chk("rst_resp_rdata", resp_rdata, 32'd0);
        chk("rst_mem_address", mem_address, 32'd0);
        chk("rst_mem_write_data", mem_write_data, 32'd0);
        @(negedge clk);
        reset = 1'b0;

        // Word store then word load.
        issue(1'b1, 2'b10, 1'b0, 32'h10, 32'hDEADBEEF, 1'b1);
        idle();
        drain();
        chk("st_word_mem4", mem_arr[4], 32'hDEADBEEF);
        issue(1'b0, 2'b10, 1'b0, 32'h10, 32'h0, 1'b1);
        idle();
        drain();
        chk("ld_word_rdata", resp_rdata, 32'hDEADBEEF);

        // Byte store RMW; upper store-data bits must be ignored.
        issue(1'b1, 2'b10, 1'b0, 32'h10, 32'h11223344, 1'b1);
        issue(1'b1, 2'b00, 1'b0, 32'h12, 32'hFFFF_FFAA, 1'b1);
        idle();
        drain();
        chk("rmw_byte_mem4", mem_arr[4], 32'h11AA3344);

        // Load extension, issued back to back with req_valid held high.
        issue(1'b1, 2'b10, 1'b0, 32'h10, 32'h80FF7F01, 1'b1);
        issue(1'b0, 2'b00, 1'b1, 32'h12, 32'h0, 1'b1);
        issue(1'b0, 2'b01, 1'b0, 32'h12, 32'h0, 1'b1);
        issue(1'b0, 2'b00, 1'b1, 32'h10, 32'h0, 1'b1);
        idle();
        drain();
        chk("ld_sbyte_lane0", resp_rdata, 32'h0000_0001);

        // Misaligned word load.
        issue(1'b0, 2'b10, 1'b0, 32'h11, 32'h0, 1'b1);
        idle();
        drain();

        // Reset while the RMW read is in flight.
        issue(1'b1, 2'b10, 1'b0, 32'h10, 32'h11223344, 1'b1);
        idle();
        drain();
        issue(1'b1, 2'b00, 1'b0, 32'h12, 32'h0000_00AA, 1'b0);
        @(negedge clk);
        req_valid = 1'b0;
        #2;
        reset = 1'b1;
        #1;
        chk("rst_mid_ready", {31'd0, req_ready}, 32'd1);
        chk("rst_mid_strobes", {30'd0, mem_read, mem_write}, 32'd0);
        last_rdata = 32'h0;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        repeat (4) @(negedge clk);
        chk("rst_mid_mem4", mem_arr[4], 32'h11223344);

        // Randomized traffic.
        for (int k = 0; k < 300; k++) begin
            issue(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                  32'($urandom_range(0, 63)), $urandom, 1'b1);
            if ($urandom_range(0, 2) == 0) idle();
        end
        idle();
        drain();
        for (int i = 0; i < 16; i++) begin
            chk("final_mem", mem_arr[i], ref_mem[i]);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
